j_rdsyncr32: RTL and testbench
==============================

Name: j_rdsyncr32

Overview:
- Read-side counterpart of Jerry's 32-bit synchronous load registers.
- Takes a coherent snapshot of a 32-bit internal value and returns it to the 16-bit host bus as two word reads.
- Neither half can tear: the snapshot is frozen until both halves have been read, or until a timeout discards it.
- Sits between a 32-bit source (timer, DSP result register) and the Jerry register-read mux.

Parameters:
TMO_W, 8, width of the half-read timeout counter.
TMO_EN, 1, 1 = discard a half-read snapshot after 2^TMO_W-1 idle cycles; 0 = never discard.

Ports:
clk  in  1  functional clock; all state is updated on its rising edge.
rst_n  in  1  asynchronous active-low reset.
src_d  in  [0:31]  source value; bit 0 = LSB (codebase [0:n] ordering).
src_vld  in  1  source offers src_d this cycle.
src_ack  out  1  one-cycle pulse: src_d was captured this edge.
rd_req  in  1  host read strobe; each high cycle is one read.
rd_hi  in  1  1 = read bits 16..31, 0 = read bits 0..15; sampled with rd_req.
rd_ack  out  1  one-cycle pulse, one clk after rd_req.
dout  out  [0:15]  read data; valid with rd_ack, held until the next rd_ack.
full  out  1  a snapshot is held (state FULL or HALF).
udr  out  1  sticky: a read occurred while EMPTY; cleared by a read in FULL.
stale  out  1  sticky: a snapshot was discarded by timeout; cleared on the next capture.

Behaviour:
- Reset (async, rst_n low): state EMPTY; snap=0, dout=0, src_ack=0, rd_ack=0, udr=0, stale=0, tmo counter=0, first_hi=0. Reset mid-read drops the snapshot and any pending rd_ack.
- States (2-bit): EMPTY, FULL (captured, nothing read), HALF (one half read).
- Capture: in EMPTY with src_vld=1, snap<=src_d, src_ack=1 on the next edge, state goes to FULL. In FULL or HALF, src_vld gets no src_ack; the source must hold its offer (backpressure).
- Read latency:
  - rd_req at edge N gives rd_ack=1 and dout valid after edge N+1.
  - dout = snap[16:31] if rd_hi, else snap[0:15].
  - rd_ack is high for exactly one cycle per rd_req cycle; back-to-back rd_req gives back-to-back rd_ack.
- Read transitions:
  - EMPTY: dout = current (stale) snap half, udr<=1, state unchanged.
  - FULL: state goes to HALF, first_hi<=rd_hi, tmo<=0, udr<=0.
  - HALF with rd_hi==first_hi: same half returned again, state stays HALF, tmo<=0.
  - HALF with rd_hi!=first_hi: read completes, state goes to EMPTY.
- Completion and capture in the same cycle:
  - If a completing read and src_vld coincide, dout carries the old snap half.
  - snap<=src_d and src_ack=1 in the same cycle; state goes to FULL. No idle bubble.
- Timeout (TMO_EN=1):
  - In HALF, tmo increments each cycle without a read and saturates at all-ones.
  - When tmo reaches all-ones, state goes to EMPTY and stale<=1.
  - If a completing read lands on the expiry cycle, the read wins: the data is returned and stale is not set.
- full = (state != EMPTY); registered, combinational from state only.
- Width rules: no arithmetic on data. tmo is unsigned TMO_W bits, saturating with no wrap.

Decomposition:
- Shared jerry package: state encoding constants (RS_EMPTY=0, RS_FULL=1, RS_HALF=2).
- Also in the package: half-select constants HI=1, LO=0.
- Natural sub-module: j_rdsync_tmo, the saturating TMO_W counter with clear, enable and expiry flag. It is reusable by other Jerry readback blocks.
- Data snapshot: a flat 32-bit register with load enable, inline.

Test Plan:
- Capture then read: src_d=0x12345678 with src_vld, then rd_req hi, then rd_req lo. Expect src_ack 1 cycle later; dout=0x1234 then 0x5678; full goes 1→1→0.
- Coherency: capture 0xAAAA5555, read lo, then change src_d to 0xFFFF0000 with src_vld held, then read hi. Expect 0x5555 then 0xAAAA; no src_ack until after the hi read.
- Repeated half: capture 0xCAFEBABE, read hi twice, then read lo. Expect 0xCAFE, 0xCAFE, 0xBABE; state HALF until the lo read.
- Underrun: read after reset with no capture. Expect rd_ack, dout=0x0000, udr=1. Then capture and read one half: udr clears.
- Timeout: TMO_W=4. Capture 0x0000BEEF, read lo, idle 15 cycles. Expect full=0 and stale=1; the next src_vld captures and clears stale.
- Reset mid-op: assert rst_n low in HALF with rd_req pending. Expect all outputs 0 immediately (async), no rd_ack after release, state EMPTY.

Source files
------------

// File: rtl/j_rdsyncr32_pkg.sv
// j_rdsyncr32_pkg
// Shared definitions for the Jerry 32-bit readback path: the snapshot state
// encoding, the half-select constants used with rd_hi, and a helper that
// picks one 16-bit half out of a 32-bit word.
//
// Word layout uses the codebase [0:n] ordering with index 0 as the LSB, so
// word[0:15] is the low half and word[16:31] is the high half.

package j_rdsyncr32_pkg;

  // Snapshot lifecycle: nothing held, held and untouched, one half handed out.
  typedef enum logic [1:0] {
    RS_EMPTY = 2'd0,
    RS_FULL  = 2'd1,
    RS_HALF  = 2'd2
  } rs_state_t;

  // Values of rd_hi selecting each half of the word.
  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;

  // Return the requested 16-bit half of a 32-bit [0:31] word.
  function automatic logic [0:15] half_of(input logic [0:31] word,
                                          input logic        hi);
    logic [0:15] half;
    if (hi == HI) begin
      half = word[16:31];
    end else begin
      half = word[0:15];
    end
    return half;
  endfunction

endpackage

// File: rtl/j_rdsync_tmo.sv
// j_rdsync_tmo
// Saturating idle counter shared by the Jerry readback blocks. A readback
// block clears it whenever the host touches a held value and enables it on
// every cycle the host leaves that value half-read. The expire flag fires on
// the enabled cycle whose increment brings the count to all-ones, i.e. after
// 2^TMO_W-1 consecutive idle cycles, so the owner can drop the value on that
// same edge. Once at all-ones the count stays there until cleared.
//
// Ports:
//   clk     functional clock, rising edge
//   rst_n   asynchronous active-low reset, count returns to zero
//   clr     synchronous clear, has priority over en
//   en      count this cycle (saturates at all-ones)
//   expire  combinational: this enabled cycle completes the timeout

module j_rdsync_tmo #(
  parameter int TMO_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TMO_W-1:0] CNT_MAX  = {TMO_W{1'b1}};
  localparam logic [TMO_W-1:0] CNT_LAST = CNT_MAX - 1'b1;

  logic [TMO_W-1:0] count;

  // Idle counter: clear wins over enable, and the count never wraps back to
  // zero on its own, so a long-idle owner cannot see a second expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  // Flag the step onto all-ones so the owner reacts on exactly the
  // 2^TMO_W-1'th idle edge rather than one cycle later.
  assign expire = en && !clr && (count == CNT_LAST);

endmodule

// File: rtl/j_rdsyncr32.sv
// j_rdsyncr32
// Read-side synchronous register for Jerry. A 32-bit source value is frozen
// into a snapshot and handed to the 16-bit host bus as two word reads. The
// snapshot cannot change between the two halves, so the host always sees a
// coherent 32-bit value. A half-read snapshot is dropped after 2^TMO_W-1
// idle cycles when TMO_EN is set, which raises the sticky stale flag.
//
// Ports:
//   clk      functional clock, rising edge
//   rst_n    asynchronous active-low reset
//   src_d    source value [0:31], index 0 = LSB
//   src_vld  source offers src_d this cycle; must be held until src_ack
//   src_ack  one-cycle pulse, src_d was captured on this edge
//   rd_req   host read strobe, one read per high cycle
//   rd_hi    half select sampled with rd_req (1 = bits 16..31)
//   rd_ack   one-cycle pulse one clock after each rd_req cycle
//   dout     read data [0:15], valid with rd_ack and held until the next one
//   full     a snapshot is held
//   udr      sticky underrun: a read arrived with nothing held
//   stale    sticky: a half-read snapshot was discarded by timeout

module j_rdsyncr32 #(
  parameter int TMO_W  = 8,
  parameter bit TMO_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:31] src_d,
  input  logic        src_vld,
  output logic        src_ack,
  input  logic        rd_req,
  input  logic        rd_hi,
  output logic        rd_ack,
  output logic [0:15] dout,
  output logic        full,
  output logic        udr,
  output logic        stale
);

  import j_rdsyncr32_pkg::*;

  rs_state_t   state;
  logic [0:31] snap;
  logic        first_hi;

  logic rd_empty;
  logic rd_first;
  logic rd_repeat;
  logic rd_done;
  logic capture;
  logic tmo_clr;
  logic tmo_en;
  logic tmo_exp;
  logic timeout;

  // Classify this cycle's read against the current state. A completing read
  // frees the snapshot on the same edge, so a waiting source is captured
  // immediately instead of losing a cycle in EMPTY.
  always_comb begin
    rd_empty  = 1'b0;
    rd_first  = 1'b0;
    rd_repeat = 1'b0;
    rd_done   = 1'b0;
    if (rd_req) begin
      unique case (state)
        RS_EMPTY: rd_empty  = 1'b1;
        RS_FULL:  rd_first  = 1'b1;
        RS_HALF: begin
          if (rd_hi == first_hi) begin
            rd_repeat = 1'b1;
          end else begin
            rd_done = 1'b1;
          end
        end
        default: rd_empty = 1'b1;
      endcase
    end
    capture = src_vld && ((state == RS_EMPTY) || rd_done);
    tmo_clr = rd_first || rd_repeat;
    tmo_en  = (state == RS_HALF) && !rd_req;
  end

  j_rdsync_tmo #(
    .TMO_W (TMO_W)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_exp)
  );

  // Expiry only counts while idle in HALF, so a read landing on the expiry
  // cycle suppresses it and the read completes normally.
  assign timeout = TMO_EN && tmo_exp;

  // Snapshot register and every registered output live in one block so the
  // state, data and handshake pulses always move together on the same edge.
  // A read while EMPTY still returns the old snapshot half; that is only
  // flagged via udr, never blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RS_EMPTY;
      snap     <= '0;
      first_hi <= 1'b0;
      dout     <= '0;
      src_ack  <= 1'b0;
      rd_ack   <= 1'b0;
      udr      <= 1'b0;
      stale    <= 1'b0;
    end else begin
      src_ack <= capture;
      rd_ack  <= rd_req;

      if (rd_req) begin
        dout <= half_of(snap, rd_hi);
      end

      if (capture) begin
        snap <= src_d;
      end

      if (rd_first) begin
        first_hi <= rd_hi;
      end

      if (rd_empty) begin
        udr <= 1'b1;
      end else if (rd_first) begin
        udr <= 1'b0;
      end

      if (capture) begin
        stale <= 1'b0;
      end else if (timeout) begin
        stale <= 1'b1;
      end

      unique case (state)
        RS_EMPTY: begin
          if (capture) begin
            state <= RS_FULL;
          end
        end
        RS_FULL: begin
          if (rd_first) begin
            state <= RS_HALF;
          end
        end
        RS_HALF: begin
          if (capture) begin
            state <= RS_FULL;
          end else if (rd_done || timeout) begin
            state <= RS_EMPTY;
          end
        end
        default: state <= RS_EMPTY;
      endcase
    end
  end

  // Decoded straight from the state register so it switches with the edge.
  assign full = (state != RS_EMPTY);

endmodule

// File: tb/tb_j_rdsyncr32.sv
// tb_j_rdsyncr32
// Self-checking bench for j_rdsyncr32 with a short timeout (TMO_W=4).
// Words in the bench are ordinary [31:0] numbers; on the DUT buses bus index i
// carries weight 2^i, so values are bit-mapped on the way in and out.
// A reference model tracks the snapshot lifecycle in plain terms (held,
// partially read, idle cycle count) and is advanced on every clock.

module tb_j_rdsyncr32;

  import j_rdsyncr32_pkg::*;

  localparam int TMO_W  = 4;
  localparam bit TMO_EN = 1'b1;
  localparam int TMO_IDLE = (1 << TMO_W) - 1;

  logic        clk;
  logic        rst_n;
  logic [0:31] src_d;
  logic        src_vld;
  logic        src_ack;
  logic        rd_req;
  logic        rd_hi;
  logic        rd_ack;
  logic [0:15] dout;
  logic        full;
  logic        udr;
  logic        stale;

  int errors;
  int checks;

  // Reference model
  logic [31:0] m_snap;
  bit          m_held;
  bit          m_partial;
  bit          m_first_hi;
  int          m_idle;
  bit          m_udr;
  bit          m_stale;
  logic [15:0] exp_dout;
  bit          exp_rd_ack;
  bit          exp_src_ack;

  j_rdsyncr32 #(
    .TMO_W  (TMO_W),
    .TMO_EN (TMO_EN)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .src_d   (src_d),
    .src_vld (src_vld),
    .src_ack (src_ack),
    .rd_req  (rd_req),
    .rd_hi   (rd_hi),
    .rd_ack  (rd_ack),
    .dout    (dout),
    .full    (full),
    .udr     (udr),
    .stale   (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [0:31] to_bus(input logic [31:0] v);
    logic [0:31] b;
    for (int i = 0; i < 32; i++) b[i] = v[i];
    return b;
  endfunction

  function automatic logic [15:0] from_bus(input logic [0:15] b);
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = b[i];
    return v;
  endfunction

  task automatic model_reset();
    m_snap      = '0;
    m_held      = 0;
    m_partial   = 0;
    m_first_hi  = 0;
    m_idle      = 0;
    m_udr       = 0;
    m_stale     = 0;
    exp_dout    = '0;
    exp_rd_ack  = 0;
    exp_src_ack = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, and leave
  // time 1 unit after the edge so outputs can be sampled.
  task automatic step(input bit vld, input logic [31:0] d, input bit req, input bit hi);
    bit held_before;
    bit completes;
    src_vld = vld;
    src_d   = to_bus(d);
    rd_req  = req;
    rd_hi   = hi;
    @(posedge clk);
    held_before = m_held;
    completes   = 0;
    exp_rd_ack  = req;
    exp_src_ack = 0;
    if (req) begin
      exp_dout = hi ? m_snap[31:16] : m_snap[15:0];
      if (!m_held) begin
        m_udr = 1;
      end else if (!m_partial) begin
        m_partial  = 1;
        m_first_hi = hi;
        m_idle     = 0;
        m_udr      = 0;
      end else if (hi == m_first_hi) begin
        m_idle = 0;
      end else begin
        m_held    = 0;
        m_partial = 0;
        completes = 1;
      end
    end else if (m_held && m_partial && TMO_EN) begin
      m_idle++;
      if (m_idle == TMO_IDLE) begin
        m_held    = 0;
        m_partial = 0;
        m_stale   = 1;
      end
    end
    if (vld && (!held_before || completes)) begin
      m_snap      = d;
      m_held      = 1;
      m_partial   = 0;
      m_stale     = 0;
      exp_src_ack = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    src_vld = 0; src_d = '0; rd_req = 0; rd_hi = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (src_ack !== 1'b0) begin errors++; $display("[TB] FAIL rst_src_ack: got %0b want 0", src_ack); end
    checks++; if (rd_ack !== 1'b0) begin errors++; $display("[TB] FAIL rst_rd_ack: got %0b want 0", rd_ack); end
    checks++; if (from_bus(dout) !== 16'h0000) begin errors++; $display("[TB] FAIL rst_dout: got %h want 0000", from_bus(dout)); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL rst_full: got %0b want 0", full); end
    checks++; if (udr !== 1'b0) begin errors++; $display("[TB] FAIL rst_udr: got %0b want 0", udr); end
    checks++; if (stale !== 1'b0) begin errors++; $display("[TB] FAIL rst_stale: got %0b want 0", stale); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_underrun();
    step(0, 32'h0, 1, LO);
    checks++; if (rd_ack !== 1'b1) begin errors++; $display("[TB] FAIL udr_rd_ack: got %0b want 1", rd_ack); end
    checks++; if (from_bus(dout) !== 16'h0000) begin errors++; $display("[TB] FAIL udr_dout: got %h want 0000", from_bus(dout)); end
    checks++; if (udr !== 1'b1) begin errors++; $display("[TB] FAIL udr_set: got %0b want 1", udr); end
    step(1, 32'h0F0F1234, 0, LO);
    checks++; if (src_ack !== 1'b1) begin errors++; $display("[TB] FAIL udr_src_ack: got %0b want 1", src_ack); end
    checks++; if (udr !== 1'b1) begin errors++; $display("[TB] FAIL udr_hold: got %0b want 1", udr); end
    step(0, 32'h0, 1, HI);
    checks++; if (from_bus(dout) !== 16'h0F0F) begin errors++; $display("[TB] FAIL udr_hi_dout: got %h want 0f0f", from_bus(dout)); end
    checks++; if (udr !== 1'b0) begin errors++; $display("[TB] FAIL udr_clear: got %0b want 0", udr); end
    step(0, 32'h0, 1, LO);
    checks++; if (from_bus(dout) !== 16'h1234) begin errors++; $display("[TB] FAIL udr_lo_dout: got %h want 1234", from_bus(dout)); end
  endtask

  task automatic test_capture_read();
    step(1, 32'h12345678, 0, LO);
    checks++; if (src_ack !== 1'b1) begin errors++; $display("[TB] FAIL cap_src_ack: got %0b want 1", src_ack); end
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL cap_full: got %0b want 1", full); end
    step(0, 32'h0, 0, LO);
    checks++; if (src_ack !== 1'b0) begin errors++; $display("[TB] FAIL cap_ack_pulse: got %0b want 0", src_ack); end
    step(0, 32'h0, 1, HI);
    checks++; if (rd_ack !== 1'b1) begin errors++; $display("[TB] FAIL cap_rd_ack: got %0b want 1", rd_ack); end
    checks++; if (from_bus(dout) !== 16'h1234) begin errors++; $display("[TB] FAIL cap_hi_dout: got %h want 1234", from_bus(dout)); end
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL cap_half_full: got %0b want 1", full); end
    step(0, 32'h0, 1, LO);
    checks++; if (from_bus(dout) !== 16'h5678) begin errors++; $display("[TB] FAIL cap_lo_dout: got %h want 5678", from_bus(dout)); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL cap_done_full: got %0b want 0", full); end
    step(0, 32'h0, 0, LO);
    checks++; if (rd_ack !== 1'b0) begin errors++; $display("[TB] FAIL cap_rd_pulse: got %0b want 0", rd_ack); end
    checks++; if (from_bus(dout) !== 16'h5678) begin errors++; $display("[TB] FAIL cap_dout_hold: got %h want 5678", from_bus(dout)); end
  endtask

  task automatic test_coherency();
    step(1, 32'hAAAA5555, 0, LO);
    step(0, 32'h0, 1, LO);
    checks++; if (from_bus(dout) !== 16'h5555) begin errors++; $display("[TB] FAIL coh_lo_dout: got %h want 5555", from_bus(dout)); end
    for (int i = 0; i < 3; i++) begin
      step(1, 32'hFFFF0000, 0, LO);
      checks++; if (src_ack !== 1'b0) begin errors++; $display("[TB] FAIL coh_backpressure: got %0b want 0", src_ack); end
    end
    step(1, 32'hFFFF0000, 1, HI);
    checks++; if (from_bus(dout) !== 16'hAAAA) begin errors++; $display("[TB] FAIL coh_hi_dout: got %h want aaaa", from_bus(dout)); end
    checks++; if (src_ack !== 1'b1) begin errors++; $display("[TB] FAIL coh_recapture: got %0b want 1", src_ack); end
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL coh_full: got %0b want 1", full); end
    step(0, 32'h0, 1, LO);
    checks++; if (from_bus(dout) !== 16'h0000) begin errors++; $display("[TB] FAIL coh_new_lo: got %h want 0000", from_bus(dout)); end
    step(0, 32'h0, 1, HI);
    checks++; if (from_bus(dout) !== 16'hFFFF) begin errors++; $display("[TB] FAIL coh_new_hi: got %h want ffff", from_bus(dout)); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL coh_done_full: got %0b want 0", full); end
  endtask

  task automatic test_repeat_half();
    step(1, 32'hCAFEBABE, 0, LO);
    step(0, 32'h0, 1, HI);
    checks++; if (from_bus(dout) !== 16'hCAFE) begin errors++; $display("[TB] FAIL rep_hi1: got %h want cafe", from_bus(dout)); end
    step(0, 32'h0, 1, HI);
    checks++; if (from_bus(dout) !== 16'hCAFE) begin errors++; $display("[TB] FAIL rep_hi2: got %h want cafe", from_bus(dout)); end
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL rep_still_full: got %0b want 1", full); end
    step(0, 32'h0, 1, LO);
    checks++; if (from_bus(dout) !== 16'hBABE) begin errors++; $display("[TB] FAIL rep_lo: got %h want babe", from_bus(dout)); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL rep_done_full: got %0b want 0", full); end
  endtask

  task automatic test_timeout();
    step(1, 32'h0000BEEF, 0, LO);
    step(0, 32'h0, 1, LO);
    checks++; if (from_bus(dout) !== 16'hBEEF) begin errors++; $display("[TB] FAIL tmo_lo_dout: got %h want beef", from_bus(dout)); end
    repeat (TMO_IDLE - 1) step(0, 32'h0, 0, LO);
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL tmo_early: got full=%0b want 1", full); end
    checks++; if (stale !== 1'b0) begin errors++; $display("[TB] FAIL tmo_early_stale: got %0b want 0", stale); end
    step(0, 32'h0, 0, LO);
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL tmo_expire_full: got %0b want 0", full); end
    checks++; if (stale !== 1'b1) begin errors++; $display("[TB] FAIL tmo_expire_stale: got %0b want 1", stale); end
    step(1, 32'h13572468, 0, LO);
    checks++; if (src_ack !== 1'b1) begin errors++; $display("[TB] FAIL tmo_recap_ack: got %0b want 1", src_ack); end
    checks++; if (stale !== 1'b0) begin errors++; $display("[TB] FAIL tmo_stale_clear: got %0b want 1->0", stale); end
    // Completing read on the expiry cycle wins over the timeout.
    step(0, 32'h0, 1, LO);
    repeat (TMO_IDLE - 1) step(0, 32'h0, 0, LO);
    step(0, 32'h0, 1, HI);
    checks++; if (from_bus(dout) !== 16'h1357) begin errors++; $display("[TB] FAIL tmo_race_dout: got %h want 1357", from_bus(dout)); end
    checks++; if (stale !== 1'b0) begin errors++; $display("[TB] FAIL tmo_race_stale: got %0b want 0", stale); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL tmo_race_full: got %0b want 0", full); end
  endtask

  task automatic test_back_to_back();
    step(1, 32'h89ABCDEF, 0, LO);
    step(0, 32'h0, 1, HI);
    checks++; if (rd_ack !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ack1: got %0b want 1", rd_ack); end
    step(1, 32'h01234567, 1, LO);
    checks++; if (rd_ack !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ack2: got %0b want 1", rd_ack); end
    checks++; if (from_bus(dout) !== 16'hCDEF) begin errors++; $display("[TB] FAIL b2b_dout2: got %h want cdef", from_bus(dout)); end
    checks++; if (src_ack !== 1'b1) begin errors++; $display("[TB] FAIL b2b_src_ack: got %0b want 1", src_ack); end
    step(0, 32'h0, 1, LO);
    checks++; if (rd_ack !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ack3: got %0b want 1", rd_ack); end
    checks++; if (from_bus(dout) !== 16'h4567) begin errors++; $display("[TB] FAIL b2b_dout3: got %h want 4567", from_bus(dout)); end
    step(0, 32'h0, 1, HI);
    checks++; if (from_bus(dout) !== 16'h0123) begin errors++; $display("[TB] FAIL b2b_dout4: got %h want 0123", from_bus(dout)); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL b2b_full: got %0b want 0", full); end
  endtask

  task automatic test_reset_midop();
    step(1, 32'h11112222, 0, LO);
    step(0, 32'h0, 1, HI);
    rd_req = 1'b1;
    rd_hi  = LO;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rd_ack !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_rd_ack: got %0b want 0", rd_ack); end
    checks++; if (from_bus(dout) !== 16'h0000) begin errors++; $display("[TB] FAIL mid_async_dout: got %h want 0000", from_bus(dout)); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_full: got %0b want 0", full); end
    @(posedge clk);
    #1;
    checks++; if (rd_ack !== 1'b0) begin errors++; $display("[TB] FAIL mid_held_rd_ack: got %0b want 0", rd_ack); end
    rd_req = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    step(0, 32'h0, 0, LO);
    checks++; if (rd_ack !== 1'b0) begin errors++; $display("[TB] FAIL mid_release_rd_ack: got %0b want 0", rd_ack); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL mid_release_full: got %0b want 0", full); end
    step(0, 32'h0, 1, HI);
    checks++; if (udr !== 1'b1) begin errors++; $display("[TB] FAIL mid_empty_udr: got %0b want 1", udr); end
    checks++; if (from_bus(dout) !== 16'h0000) begin errors++; $display("[TB] FAIL mid_snap_cleared: got %h want 0000", from_bus(dout)); end
  endtask

  task automatic test_random();
    bit          vld;
    bit          req;
    bit          hi;
    logic [31:0] d;
    int          req_pct;
    for (int blk = 0; blk < 8; blk++) begin
      req_pct = (blk % 2 == 0) ? 50 : 4;
      for (int i = 0; i < 60; i++) begin
        vld = ($urandom_range(0, 99) < 40);
        req = ($urandom_range(0, 99) < req_pct);
        hi  = $urandom_range(0, 1);
        d   = $urandom;
        step(vld, d, req, hi);
        checks++; if (src_ack !== exp_src_ack) begin errors++; $display("[TB] FAIL rnd_src_ack: got %0b want %0b", src_ack, exp_src_ack); end
        checks++; if (rd_ack !== exp_rd_ack) begin errors++; $display("[TB] FAIL rnd_rd_ack: got %0b want %0b", rd_ack, exp_rd_ack); end
        checks++; if (from_bus(dout) !== exp_dout) begin errors++; $display("[TB] FAIL rnd_dout: got %h want %h", from_bus(dout), exp_dout); end
        checks++; if (full !== m_held) begin errors++; $display("[TB] FAIL rnd_full: got %0b want %0b", full, m_held); end
        checks++; if (udr !== m_udr) begin errors++; $display("[TB] FAIL rnd_udr: got %0b want %0b", udr, m_udr); end
        checks++; if (stale !== m_stale) begin errors++; $display("[TB] FAIL rnd_stale: got %0b want %0b", stale, m_stale); end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_reset();
    test_reset();
    test_underrun();
    test_capture_read();
    test_coherency();
    test_repeat_half();
    test_timeout();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
